sub_shift_rows: RTL

SUB_SHIFT_ROWS -- requirements
Module: sub_shift_rows

---
 rtl/sub_shift_rows.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sub_shift_rows.sv
// Iterative SubBytes + ShiftRows stage of an AES round (column-major 128-bit state).
// Define SUB_SHIFT_PARALLEL_EN to substitute all 16 bytes in a single SUB cycle.

package hea_func_pack;

    // FIPS-197 forward S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 2047 - 8 * int'(b);
        return SBOX_TBL[idx -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

module sub_shift_rows
    import hea_func_pack::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // the producer holds data stable until that edge, and valid never drops
    // without a transfer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] st_q, st_d;
    logic [127:0] st_sub;
    logic [127:0] shifted;

`ifdef SUB_SHIFT_PARALLEL_EN
    always_comb begin
        st_sub = '0;
        for (int i = 0; i < 4; i++) begin
            st_sub[32*i +: 32] = sub_word(st_q[32*i +: 32]);
        end
    end
`else
    logic [31:0] col_word;
    logic [31:0] col_sub;

    // One column per cycle through a shared bank of four S-boxes.
    always_comb begin
        col_word = st_q[127:96];
        case (col_q)
            2'd0:    col_word = st_q[127:96];
            2'd1:    col_word = st_q[95:64];
            2'd2:    col_word = st_q[63:32];
            default: col_word = st_q[31:0];
        endcase
        col_sub = sub_word(col_word);
        st_sub  = st_q;
        case (col_q)
            2'd0:    st_sub[127:96] = col_sub;
            2'd1:    st_sub[95:64]  = col_sub;
            2'd2:    st_sub[63:32]  = col_sub;
            default: st_sub[31:0]   = col_sub;
        endcase
    end
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        st_d    = st_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = in_state;
                    col_d   = 2'd0;
                    state_d = SUB;
                end
            end
            SUB: begin
                st_d = st_sub;
`ifdef SUB_SHIFT_PARALLEL_EN
                state_d = DONE;
`else
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            st_q    <= st_d;
        end
    end

    // Byte (r,c) lives at bit 127-8*(4c+r); row r rotates left by r columns.
    always_comb begin
        shifted = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                shifted[127 - 8*(4*c + r) -: 8] = st_q[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_state = (state_q == DONE) ? shifted : 128'h0;

endmodule
